// File: rtl/ym_multi_ctrl.sv
// ============================================================================
// Module   : ym_multi_ctrl
// Brief    : TurboSound controller for up to 8 AY/YM2149 chips, with beeper,
//            tape-out and covox ports, plus the YM clock divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ym_multi_ctrl #(
    parameter int NUM_CHIPS = 2,
    parameter int DIV_LO    = 2,
    parameter int DIV_HI    = 4
) (
    input  logic                 cpu_clock,
    input  logic                 reset,
    input  logic [3:0]           addr,
    input  logic                 iorq,
    input  logic                 m1,
    input  logic                 wr,
    input  logic                 rd,
    input  logic [7:0]           d,
    input  logic                 clk_mode,
    output logic                 ym_clock,
    output logic [NUM_CHIPS-1:0] ym_bc1,
    output logic [NUM_CHIPS-1:0] ym_bdir,
    output logic [NUM_CHIPS-1:0] ym_sel,
    output logic                 beeper,
    output logic                 tapeout,
    output logic [7:0]           covox_data,
    output logic                 covox_stb
);

    localparam int             C_DIV_MAX = (DIV_LO > DIV_HI) ? DIV_LO : DIV_HI;
    localparam int             CW        = $clog2(C_DIV_MAX);
    localparam logic [CW-1:0]  C_HLO_M1  = CW'(DIV_LO / 2 - 1);
    localparam logic [CW-1:0]  C_HHI_M1  = CW'(DIV_HI / 2 - 1);
    localparam logic [3:0]     C_NUM     = 4'(NUM_CHIPS);
    localparam logic [NUM_CHIPS-1:0] C_SEL_RST = NUM_CHIPS'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CYCLE   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // Address bus is {a15, a14, a1, a0}
    logic w_a15, w_a14, w_a1, w_a0;
    logic w_ssg, w_ssg_wr, w_ssg_rd, w_fe_wr, w_cv_wr, w_io_act;
    logic w_sel_cmd, w_sel_ok, w_bc1_cond;
    logic [2:0]           w_sel_idx;
    logic [NUM_CHIPS-1:0] w_idx_oh;

    assign w_a15      = addr[3];
    assign w_a14      = addr[2];
    assign w_a1       = addr[1];
    assign w_a0       = addr[0];
    assign w_ssg      = w_a15 & ~w_a1 & ~iorq & m1;
    assign w_ssg_wr   = w_ssg & ~wr;
    assign w_ssg_rd   = w_ssg & ~rd;
    assign w_fe_wr    = ~iorq & ~wr & ~w_a0;
    assign w_cv_wr    = ~iorq & ~wr & w_a0 & w_a1 & ~w_a15;
    assign w_io_act   = ~iorq & m1;
    assign w_bc1_cond = w_a14 & (w_ssg_wr | w_ssg_rd);
    assign w_sel_cmd  = w_ssg_wr & w_a14 & (d[7:3] == 5'b11111);
    assign w_sel_idx  = ~d[2:0];
    assign w_sel_ok   = ({1'b0, w_sel_idx} < C_NUM);

    for (genvar g = 0; g < NUM_CHIPS; g++) begin : g_sel_oh
        assign w_idx_oh[g] = (w_sel_idx == 3'(g));
    end

    // ---------------- bus-cycle detector ----------------
    state_t state_q, state_d;
    logic   w_strobe, w_active;

    always_comb begin
        state_d  = state_q;
        w_strobe = 1'b0;
        w_active = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_io_act) begin
                    w_strobe = 1'b1;
                    w_active = 1'b1;
                    state_d  = S_CYCLE;
                end
            end
            S_CYCLE: begin
                if (w_io_act) w_active = 1'b1;
                else          state_d  = S_IDLE;
            end
            S_RELEASE: begin
                if (!w_io_act) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    logic [NUM_CHIPS-1:0] sel_q, sel_d, bdir_q, bdir_d, bc1_q, bc1_d;
    logic                 beeper_q, beeper_d, tape_q, tape_d, cv_stb_q, cv_stb_d;
    logic [7:0]           cv_data_q, cv_data_d;

    always_comb begin
        sel_d     = sel_q;
        bdir_d    = '0;
        bc1_d     = '0;
        beeper_d  = beeper_q;
        tape_d    = tape_q;
        cv_data_d = cv_data_q;
        cv_stb_d  = 1'b0;
        if (w_strobe && w_sel_cmd && w_sel_ok) sel_d = w_idx_oh;
        // Select commands are swallowed here so no chip ever latches them
        if (w_active && !w_sel_cmd) begin
            if (w_ssg_wr)   bdir_d = sel_q;
            if (w_bc1_cond) bc1_d  = sel_q;
        end
        if (w_strobe && w_fe_wr) begin
            beeper_d = d[4];
            tape_d   = d[3];
        end
        if (w_strobe && w_cv_wr) begin
            cv_data_d = d;
            cv_stb_d  = 1'b1;
        end
    end

    // ---------------- YM clock divider ----------------
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ymclk_q, ymclk_d, mode_q, mode_d;
    logic [CW-1:0] w_half_m1;

    assign w_half_m1 = mode_q ? C_HHI_M1 : C_HLO_M1;

    // The ratio is only re-sampled on a rising edge so every phase is whole
    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        ymclk_d = ymclk_q;
        mode_d  = mode_q;
        if (cnt_q == w_half_m1) begin
            cnt_d   = '0;
            ymclk_d = ~ymclk_q;
            if (!ymclk_q) mode_d = clk_mode;
        end
    end

    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_RELEASE;
            sel_q     <= C_SEL_RST;
            bdir_q    <= '0;
            bc1_q     <= '0;
            beeper_q  <= 1'b0;
            tape_q    <= 1'b0;
            cv_data_q <= 8'h00;
            cv_stb_q  <= 1'b0;
            cnt_q     <= '0;
            ymclk_q   <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            bdir_q    <= bdir_d;
            bc1_q     <= bc1_d;
            beeper_q  <= beeper_d;
            tape_q    <= tape_d;
            cv_data_q <= cv_data_d;
            cv_stb_q  <= cv_stb_d;
            cnt_q     <= cnt_d;
            ymclk_q   <= ymclk_d;
            mode_q    <= mode_d;
        end
    end

    assign ym_clock   = ymclk_q;
    assign ym_bc1     = bc1_q;
    assign ym_bdir    = bdir_q;
    assign ym_sel     = sel_q;
    assign beeper     = beeper_q;
    assign tapeout    = tape_q;
    assign covox_data = cv_data_q;
    assign covox_stb  = cv_stb_q;

endmodule

`default_nettype wire

// File: tb/tb_ym_multi_ctrl.sv
// ============================================================================
// Module   : tb_ym_multi_ctrl
// Brief    : Directed self-checking bench for ym_multi_ctrl (2- and 4-chip).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ym_multi_ctrl;

    localparam logic [3:0] A_FFFD = 4'b1101;
    localparam logic [3:0] A_BFFD = 4'b1001;
    localparam logic [3:0] A_FE   = 4'b0010;
    localparam logic [3:0] A_CV   = 4'b0011;

    logic       cpu_clock = 1'b0;
    logic       reset;
    logic [3:0] addr;
    logic       iorq, m1, wr, rd, clk_mode;
    logic [7:0] d;

    logic       ym_clock_a, beeper_a, tapeout_a, covox_stb_a;
    logic [1:0] ym_bc1_a, ym_bdir_a, ym_sel_a;
    logic [7:0] covox_data_a;
    logic       ym_clock_b, beeper_b, tapeout_b, covox_stb_b;
    logic [3:0] ym_bc1_b, ym_bdir_b, ym_sel_b;
    logic [7:0] covox_data_b;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] cv_q[$];
    logic [1:0] acc_bdir, acc_bc1;
    int         n_bdir, n_bc1;

    always #5 cpu_clock = ~cpu_clock;

    ym_multi_ctrl #(.NUM_CHIPS(2), .DIV_LO(2), .DIV_HI(4)) dut_a (
        .cpu_clock(cpu_clock), .reset(reset), .addr(addr), .iorq(iorq), .m1(m1),
        .wr(wr), .rd(rd), .d(d), .clk_mode(clk_mode), .ym_clock(ym_clock_a),
        .ym_bc1(ym_bc1_a), .ym_bdir(ym_bdir_a), .ym_sel(ym_sel_a), .beeper(beeper_a),
        .tapeout(tapeout_a), .covox_data(covox_data_a), .covox_stb(covox_stb_a)
    );

    ym_multi_ctrl #(.NUM_CHIPS(4), .DIV_LO(2), .DIV_HI(4)) dut_b (
        .cpu_clock(cpu_clock), .reset(reset), .addr(addr), .iorq(iorq), .m1(m1),
        .wr(wr), .rd(rd), .d(d), .clk_mode(clk_mode), .ym_clock(ym_clock_b),
        .ym_bc1(ym_bc1_b), .ym_bdir(ym_bdir_b), .ym_sel(ym_sel_b), .beeper(beeper_b),
        .tapeout(tapeout_b), .covox_data(covox_data_b), .covox_stb(covox_stb_b)
    );

    task automatic step();
        @(posedge cpu_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [3:0] a, input logic [7:0] data, input logic is_rd);
        addr = a;
        d    = data;
        m1   = 1'b1;
        iorq = 1'b0;
        wr   = is_rd;
        rd   = ~is_rd;
    endtask

    task automatic end_op();
        iorq = 1'b1;
        wr   = 1'b1;
        rd   = 1'b1;
    endtask

    task automatic accumulate();
        acc_bdir = acc_bdir | ym_bdir_a;
        acc_bc1  = acc_bc1 | ym_bc1_a;
        if (ym_bdir_a != 2'b00) n_bdir++;
        if (ym_bc1_a != 2'b00)  n_bc1++;
    endtask

    task automatic bus_op(input logic [3:0] a, input logic [7:0] data, input logic is_rd,
                          input int hold);
        acc_bdir = '0;
        acc_bc1  = '0;
        n_bdir   = 0;
        n_bc1    = 0;
        start_op(a, data, is_rd);
        for (int i = 0; i < hold; i++) begin
            step();
            accumulate();
        end
        end_op();
        step();
        accumulate();
        step();
    endtask

    task automatic wait_level(input logic lvl);
        int n;
        n = 0;
        while (ym_clock_a !== lvl && n < 20) begin
            step();
            n++;
        end
        check("ym_wait_level", 32'(ym_clock_a), 32'(lvl));
    endtask

    task automatic run_len(output int n);
        logic v;
        n = 0;
        v = ym_clock_a;
        while (ym_clock_a === v && n < 20) begin
            step();
            n++;
        end
    endtask

    // Covox scoreboard: each pulse must match the oldest outstanding write
    always begin
        step();
        if (covox_stb_a === 1'b1) begin
            if (cv_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL covox_stb_unexpected observed=1 expected=0");
            end else begin
                check("covox_data_stb", 32'(covox_data_a), 32'(cv_q.pop_front()));
            end
        end
    end

    initial begin
        int n;
        reset    = 1'b0;
        addr     = 4'h0;
        d        = 8'h00;
        iorq     = 1'b1;
        m1       = 1'b1;
        wr       = 1'b1;
        rd       = 1'b1;
        clk_mode = 1'b0;
        step();
        step();
        check("rst_sel_a",    32'(ym_sel_a), 32'h1);
        check("rst_sel_b",    32'(ym_sel_b), 32'h1);
        check("rst_bdir",     32'(ym_bdir_a), 32'h0);
        check("rst_bc1",      32'(ym_bc1_a), 32'h0);
        check("rst_beeper",   32'(beeper_a), 32'h0);
        check("rst_tapeout",  32'(tapeout_a), 32'h0);
        check("rst_cv_stb",   32'(covox_stb_a), 32'h0);
        check("rst_cv_data",  32'(covox_data_a), 32'h0);
        check("rst_ym_clock", 32'(ym_clock_a), 32'h0);
        reset = 1'b1;
        step();

        bus_op(A_FFFD, 8'hFE, 1'b0, 3);
        check("sel_fe_a",      32'(ym_sel_a), 32'h2);
        check("sel_fe_b",      32'(ym_sel_b), 32'h2);
        check("sel_fe_nobdir", 32'(acc_bdir), 32'h0);
        check("sel_fe_nobc1",  32'(acc_bc1), 32'h0);
        bus_op(A_FFFD, 8'hFF, 1'b0, 3);
        check("sel_ff_a", 32'(ym_sel_a), 32'h1);
        check("sel_ff_b", 32'(ym_sel_b), 32'h1);
        bus_op(A_FFFD, 8'hFD, 1'b0, 3);
        check("sel_fd_a_ignored", 32'(ym_sel_a), 32'h1);
        check("sel_fd_b",         32'(ym_sel_b), 32'h4);
        check("sel_fd_nobdir",    32'(acc_bdir), 32'h0);
        bus_op(A_FFFD, 8'hFE, 1'b0, 3);
        check("sel_chip1", 32'(ym_sel_a), 32'h2);

        bus_op(A_FFFD, 8'h07, 1'b0, 4);
        check("latch_bdir_mask", 32'(acc_bdir), 32'h2);
        check("latch_bc1_mask",  32'(acc_bc1), 32'h2);
        check("latch_bdir_len",  32'(n_bdir), 32'd4);
        check("latch_bc1_len",   32'(n_bc1), 32'd4);
        bus_op(A_BFFD, 8'h3F, 1'b0, 3);
        check("wrdata_bdir_mask", 32'(acc_bdir), 32'h2);
        check("wrdata_bc1_mask",  32'(acc_bc1), 32'h0);
        check("wrdata_bdir_len",  32'(n_bdir), 32'd3);
        bus_op(A_FFFD, 8'h00, 1'b1, 3);
        check("read_bc1_mask",  32'(acc_bc1), 32'h2);
        check("read_bdir_mask", 32'(acc_bdir), 32'h0);
        check("read_bc1_len",   32'(n_bc1), 32'd3);

        start_op(A_FE, 8'h18, 1'b0);
        step();
        check("fe_beeper",  32'(beeper_a), 32'h1);
        check("fe_tapeout", 32'(tapeout_a), 32'h1);
        for (int i = 0; i < 3; i++) step();
        end_op();
        step();
        step();
        check("fe_beeper_hold", 32'(beeper_a), 32'h1);

        cv_q.push_back(8'h55);
        bus_op(A_CV, 8'h55, 1'b0, 4);
        check("cv_data_55",  32'(covox_data_a), 32'h55);
        check("cv_stb_done", 32'(covox_stb_a), 32'h0);

        // Reset lands in the middle of a covox write and lifts with iorq still low
        start_op(A_CV, 8'h33, 1'b0);
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        step();
        check("rel_cv_data", 32'(covox_data_a), 32'h00);
        check("rel_sel",     32'(ym_sel_a), 32'h1);
        end_op();
        step();
        cv_q.push_back(8'h77);
        bus_op(A_CV, 8'h77, 1'b0, 3);
        check("post_rel_cv_data", 32'(covox_data_a), 32'h77);

        wait_level(1'b0);
        wait_level(1'b1);
        run_len(n);
        check("ym_lo_high", 32'(n), 32'd1);
        run_len(n);
        check("ym_lo_low", 32'(n), 32'd1);
        clk_mode = 1'b1;
        run_len(n);
        check("ym_sw_old_high", 32'(n), 32'd1);
        run_len(n);
        check("ym_sw_old_low", 32'(n), 32'd1);
        run_len(n);
        check("ym_hi_high1", 32'(n), 32'd2);
        run_len(n);
        check("ym_hi_low1", 32'(n), 32'd2);
        run_len(n);
        check("ym_hi_high2", 32'(n), 32'd2);

        check("cv_pending", 32'(cv_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
